m_lsu_ctrl: RTL

Parametrised load/store controller for the MEM stage. It replaces the fixed 32-bit, signed-only load extender with a multi-cycle handshake engine. The engine detects misalignment, generates byte enables and lane-replicated store data, waits on a variable-latency data memory, supervises a timeout, and returns sign- or zero-extended load data. It sits between the M-stage pipeline register and the data-memory port; the pipeline stalls on busy.

---
 rtl/m_lsu_ctrl_pkg.sv | 38 +++
 rtl/m_lsu_ctrl_if.sv | 53 +++++
 rtl/m_lsu_ctrl_load_ext.sv | 44 ++++
 rtl/m_lsu_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/m_lsu_ctrl_pkg.sv
// Shared encodings for the MEM-stage load/store controller.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ERR_OK   = 2'b00,
    ERR_ADEL = 2'b01,
    ERR_ADES = 2'b10,
    ERR_TMO  = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Wide enough for the largest legal TIMEOUT (255).
  localparam int TMO_CNT_W = 8;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/m_lsu_ctrl_if.sv
// Pipeline-side and memory-side bundles of the load/store controller.

// Pipeline side: master is the M stage, slave is the controller.
interface lsu_req_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic [1:0]        resp_err;
  logic              busy;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// Memory side: master is the controller, slave is the data memory.
interface lsu_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  mem_valid;
  logic                  mem_ready;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/m_lsu_ctrl_load_ext.sv
// Lane select plus sign/zero extension of a raw memory word.
// Purely combinational so the exception/bypass path can share it.
module lsu_load_ext
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]             rdata,
  input  logic [$clog2(DATA_W/8)-1:0]   off,
  input  logic [1:0]                    size,
  input  logic                          is_unsigned,
  output logic [DATA_W-1:0]             ext
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep;
  logic              top_bit;

  // Move the addressed lane group to bit 0, then fill above it with the sign or zeros.
  // A full-width access has keep = all ones, so it passes straight through.
  always_comb begin
    shifted = rdata >> {off, 3'b000};
    case (size)
      SZ_B: begin
        keep    = DATA_W'(8'hFF);
        top_bit = shifted[7];
      end
      SZ_H: begin
        keep    = DATA_W'(16'hFFFF);
        top_bit = shifted[15];
      end
      SZ_W: begin
        keep    = DATA_W'(32'hFFFF_FFFF);
        top_bit = shifted[31];
      end
      default: begin
        keep    = '1;
        top_bit = 1'b0;
      end
    endcase
    ext = (shifted & keep) | ((top_bit && !is_unsigned) ? ~keep : '0);
  end

endmodule

// File: rtl/m_lsu_ctrl.sv
// MEM-stage load/store controller: alignment check, byte enables, lane
// replication, variable-latency memory handshake with WAIT timeout, and
// extended load return. The pipeline stalls while busy is high.
//
// state   | meaning
// IDLE    | ready for a new access; request fields latched on req_valid
// REQ     | mem_valid held with stable addr/be/wdata until mem_ready
// WAIT    | load accepted, waiting for mem_rvalid; timeout counter runs
// RESP    | one-cycle resp_valid pulse, then back to IDLE
module m_lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic       clk,
  input logic       reset_n,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);

  localparam int LANES = DATA_W / 8;
  localparam int LOG_L = $clog2(LANES);

  state_e               state;
  logic                 lat_we;
  logic                 lat_uns;
  logic [1:0]           lat_size;
  logic [LOG_L-1:0]     lat_off;
  logic [TMO_CNT_W-1:0] cnt;
  logic [DATA_W-1:0]    ld_ext;

  logic [LOG_L-1:0]     in_off;
  logic                 in_legal;
  logic [LANES-1:0]     in_mask;
  logic [LANES-1:0]     in_be;
  logic [DATA_W-1:0]    in_wdata_rep;
  logic [ADDR_W-1:0]    in_addr_al;

  // Decode the incoming request: legality, lane-aligned address, byte enables, replicated store data.
  always_comb begin
    in_off     = req.req_addr[LOG_L-1:0];
    in_legal   = ((req.req_addr[2:0] & align_mask(req.req_size)) == 3'b000) &&
                 ((req.req_size != SZ_D) || (DATA_W == 64));
    in_addr_al = {req.req_addr[ADDR_W-1:LOG_L], {LOG_L{1'b0}}};
    case (req.req_size)
      SZ_B: begin
        in_mask      = LANES'(8'h01);
        in_wdata_rep = {(LANES){req.req_wdata[7:0]}};
      end
      SZ_H: begin
        in_mask      = LANES'(8'h03);
        in_wdata_rep = {(LANES/2){req.req_wdata[15:0]}};
      end
      SZ_W: begin
        in_mask      = LANES'(8'h0F);
        in_wdata_rep = {(LANES/4){req.req_wdata[31:0]}};
      end
      default: begin
        in_mask      = '1;
        in_wdata_rep = req.req_wdata;
      end
    endcase
    in_be = in_mask << in_off;
  end

  lsu_load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .rdata       (mem.mem_rdata),
    .off         (lat_off),
    .size        (lat_size),
    .is_unsigned (lat_uns),
    .ext         (ld_ext)
  );

  // Control FSM with all handshake outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      lat_we          <= 1'b0;
      lat_uns         <= 1'b0;
      lat_size        <= 2'd0;
      lat_off         <= '0;
      cnt             <= '0;
      req.req_ready   <= 1'b1;
      req.busy        <= 1'b0;
      req.resp_valid  <= 1'b0;
      req.resp_rdata  <= '0;
      req.resp_err    <= ERR_OK;
      mem.mem_valid   <= 1'b0;
      mem.mem_addr    <= '0;
      mem.mem_be      <= '0;
      mem.mem_wdata   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req.req_valid) begin
            lat_we        <= req.req_we;
            lat_uns       <= req.req_unsigned;
            lat_size      <= req.req_size;
            lat_off       <= in_off;
            req.req_ready <= 1'b0;
            req.busy      <= 1'b1;
            if (!in_legal) begin
              state          <= ST_RESP;
              req.resp_valid <= 1'b1;
              req.resp_rdata <= '0;
              req.resp_err   <= req.req_we ? ERR_ADES : ERR_ADEL;
            end else begin
              state         <= ST_REQ;
              mem.mem_valid <= 1'b1;
              mem.mem_addr  <= in_addr_al;
              mem.mem_be    <= in_be;
              mem.mem_wdata <= in_wdata_rep;
            end
          end
        end
        ST_REQ: begin
          if (mem.mem_ready) begin
            mem.mem_valid <= 1'b0;
            mem.mem_be    <= '0;
            if (lat_we) begin
              state          <= ST_RESP;
              req.resp_valid <= 1'b1;
              req.resp_rdata <= '0;
              req.resp_err   <= ERR_OK;
            end else if (mem.mem_rvalid) begin
              state          <= ST_RESP;
              req.resp_valid <= 1'b1;
              req.resp_rdata <= ld_ext;
              req.resp_err   <= ERR_OK;
            end else begin
              state <= ST_WAIT;
              cnt   <= '0;
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          // Data arriving on the final counted cycle still wins over the timeout.
          if (mem.mem_rvalid) begin
            state          <= ST_RESP;
            req.resp_valid <= 1'b1;
            req.resp_rdata <= ld_ext;
            req.resp_err   <= ERR_OK;
          end else if (cnt == TMO_CNT_W'(TIMEOUT - 1)) begin
            state          <= ST_RESP;
            req.resp_valid <= 1'b1;
            req.resp_rdata <= '0;
            req.resp_err   <= ERR_TMO;
          end
        end
        default: begin
          state          <= ST_IDLE;
          cnt            <= '0;
          req.resp_valid <= 1'b0;
          req.req_ready  <= 1'b1;
          req.busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
